// File: rtl/jtframe_pocket_dwnld_pkg.sv
// Shared types for the Pocket bridge-to-ioctl download engine.
`default_nettype none

package jtframe_pocket_dwnld_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WAIT  = 2'd3
    } dwnld_state_t;

    localparam int unsigned BRIDGE_DW = 32;

    function automatic int unsigned lane_count(input int unsigned dw);
        return BRIDGE_DW / dw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtframe_pocket_fifo.sv
// Parametric synchronous FIFO; extra pointer MSB separates full from empty.
`default_nettype none

module jtframe_pocket_fifo #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  din_i,
    input  logic              pop_i,
    output logic [WIDTH-1:0]  dout_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q;
    logic [ADDR_W:0]   rd_ptr_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= din_i;
    end

endmodule

`default_nettype wire

// File: rtl/jtframe_pocket_dwnld.sv
// Buffered bridge-to-ioctl download engine: FIFO of 32-bit bridge words,
// serialised into DW-bit ioctl writes paced by prog_rdy.
`default_nettype none

module jtframe_pocket_dwnld
    import jtframe_pocket_dwnld_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AW      = 25,
    parameter int FIFO_AW = 3,
    parameter int BIG_END = 1
) (
    input  logic          rst_n,
    input  logic          clk_rom,
    input  logic          wr,
    input  logic [31:0]   wr_data,
    input  logic [31:0]   wr_addr,
    input  logic [7:0]    slot_id,
    input  logic          slot_done,
    input  logic          prog_rdy,
    output logic [AW-1:0] ioctl_addr,
    output logic [DW-1:0] ioctl_dout,
    output logic          ioctl_wr,
    output logic [7:0]    ioctl_index,
    output logic          downloading,
    output logic          overflow
);

    localparam int             LANES     = lane_count(DW);
    localparam int             FW        = 32 + AW - 2;
    localparam logic [1:0]     LAST_LANE = 2'(LANES - 1);
    localparam logic [AW-1:0]  LANE_STEP = AW'(DW / 8);

    dwnld_state_t   state_q, state_d;
    logic [1:0]     lane_q, lane_d;
    logic [31:0]    word_q;
    logic [AW-3:0]  waddr_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  dout_q;
    logic           wr_q;
    logic [7:0]     index_q;
    logic           dl_q;
    logic           pend_q;
    logic           ovf_q;

    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FW-1:0]  fifo_dout;
    logic           push_ok;
    logic           done_now;
    logic [31:0]    shifted;
    logic [DW-1:0]  lane_data;
    logic [AW-1:0]  lane_addr;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^{wr_addr[31:AW], wr_addr[1:0]};

    jtframe_pocket_fifo #(
        .WIDTH  (FW),
        .ADDR_W (FIFO_AW)
    ) u_fifo (
        .clk_i   (clk_rom),
        .rst_n_i (rst_n),
        .push_i  (wr),
        .din_i   ({wr_addr[AW-1:2], wr_data}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    lane_d   = 2'd0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (prog_rdy) begin
                    if (lane_q == LAST_LANE) begin
                        state_d = ST_IDLE;
                    end else begin
                        lane_d  = lane_q + 2'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift the chosen lane to the edge the output slice reads from
    always_comb begin
        if (BIG_END != 0) shifted = word_q << (int'(lane_q) * DW);
        else              shifted = word_q >> (int'(lane_q) * DW);
    end

    assign lane_data = (BIG_END != 0) ? shifted[31 -: DW] : shifted[DW-1:0];
    assign lane_addr = {waddr_q, 2'b00} + (AW'(lane_q) * LANE_STEP);

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lane_q  <= 2'd0;
            word_q  <= '0;
            waddr_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            wr_q    <= (state_q == ST_LOAD);
            if (fifo_pop) begin
                word_q  <= fifo_dout[31:0];
                waddr_q <= fifo_dout[FW-1:32];
            end
            if (state_q == ST_LOAD) begin
                addr_q <= lane_addr;
                dout_q <= lane_data;
            end
        end
    end

    assign push_ok  = wr & ~fifo_full;
    // A word arriving in the same cycle keeps the window open
    assign done_now = pend_q & fifo_empty & (state_q == ST_IDLE) & ~push_ok;

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            dl_q    <= 1'b0;
            pend_q  <= 1'b0;
            index_q <= 8'd0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr && fifo_full) ovf_q <= 1'b1;
            if (slot_done && dl_q) pend_q <= 1'b1;
            if (push_ok && !dl_q) begin
                dl_q    <= 1'b1;
                index_q <= slot_id;
            end
            if (done_now) begin
                dl_q   <= 1'b0;
                pend_q <= 1'b0;
            end
        end
    end

    assign ioctl_addr  = addr_q;
    assign ioctl_dout  = dout_q;
    assign ioctl_wr    = wr_q;
    assign ioctl_index = index_q;
    assign downloading = dl_q;
    assign overflow    = ovf_q;

endmodule

`default_nettype wire
